// File: rtl/sipo_lsb_pkg.sv
// Shared types and constants for the LSB-first serial-to-parallel converter.
package sipo_pkg;

    // Default frame length in bits.
    localparam int WIDTH_DEF = 4;

    // Frame assembly states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sipo_lsb_if.sv
// Serial-in / parallel-out bus: serial strobe, marker and data in, word plus pulses out.
interface sipo_lsb_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             enb;
    logic             l_s;
    logic             inp;
    logic [WIDTH-1:0] out;
    logic             vld;
    logic             err;

    modport master (
        output enb,
        output l_s,
        output inp,
        input  out,
        input  vld,
        input  err
    );

    modport slave (
        input  enb,
        input  l_s,
        input  inp,
        output out,
        output vld,
        output err
    );

endinterface

// File: rtl/sipo_lsb_bit_cnt.sv
// Bit-position counter for a frame: load-to-1, increment, clear, terminal flag at WIDTH-1.
module bit_cnt
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    input  logic                 clr,
    output logic [$clog2(WIDTH):0] cnt,
    output logic                 term
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] cnt_r;

    // Counter register; clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= CW'(1);
        end else if (inc) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign term = (cnt_r == CW'(WIDTH - 1));

endmodule

// File: rtl/sipo_lsb.sv
// LSB-first serial-to-parallel converter with frame-start marker, abort detection
// and one-cycle valid/error pulses.
module sipo_lsb
    import sipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    sipo_lsb_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_s;
    logic             term_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             cnt_clr_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_nxt_s;
    logic             vld_r;
    logic             vld_nxt_s;
    logic             err_r;
    logic             err_nxt_s;

    bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_s),
        .inc  (cnt_inc_s),
        .clr  (cnt_clr_s),
        .cnt  (cnt_s),
        .term (term_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: a marked strobe always (re)starts a frame.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (bus.enb && bus.l_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (bus.enb && !bus.l_s && term_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.enb && bus.l_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath control: bit placement, counter commands and next output values.
    always_comb begin
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        shreg_nxt_s = shreg_r;
        out_nxt_s   = out_r;
        vld_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.enb && bus.l_s) begin
                    cnt_load_s     = 1'b1;
                    shreg_nxt_s    = {WIDTH{1'b0}};
                    shreg_nxt_s[0] = bus.inp;
                end else begin
                    cnt_clr_s = 1'b1;
                end
            end
            SHIFT: begin
                if (bus.enb && bus.l_s) begin
                    // Premature marker: drop the partial word and start over.
                    err_nxt_s      = 1'b1;
                    cnt_load_s     = 1'b1;
                    shreg_nxt_s    = {WIDTH{1'b0}};
                    shreg_nxt_s[0] = bus.inp;
                end else if (bus.enb) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt_s == CW'(i)) begin
                            shreg_nxt_s[i] = bus.inp;
                        end else begin
                            shreg_nxt_s[i] = shreg_r[i];
                        end
                    end
                    if (term_s) begin
                        out_nxt_s = shreg_nxt_s;
                        vld_nxt_s = 1'b1;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    shreg_nxt_s = shreg_r;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Registered shift register and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            vld_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            shreg_r <= shreg_nxt_s;
            out_r   <= out_nxt_s;
            vld_r   <= vld_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.out = out_r;
    assign bus.vld = vld_r;
    assign bus.err = err_r;

endmodule

// File: doc/sipo_lsb.md
SIPO_LSB -- requirements
Module: sipo_lsb

Interface
REQ-001 Parameter WIDTH, default 4, frame length in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-004 enb  input  1  bit-strobe; a serial bit is consumed only on edges with enb=1.
REQ-005 l_s  input  1  frame-start marker; high together with enb on the first (LSB) bit of a frame.
REQ-006 inp  input  1  serial data, LSB first.
REQ-007 out  output WIDTH  last completed parallel word, registered.
REQ-008 vld  output 1  one-cycle pulse: out updated this cycle.
REQ-009 err  output 1  one-cycle pulse: frame aborted by premature l_s.

Function
REQ-010 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-011 IDLE: edge with enb=1,l_s=1 captures inp as bit 0, cnt=1, -> SHIFT; enb=1,l_s=0 ignored, stays IDLE.
REQ-012 SHIFT: edge with enb=1,l_s=0 captures inp at bit index cnt, cnt increments.
REQ-013 SHIFT, enb=0: hold shift register, cnt and state (stall, no timeout).
REQ-014 SHIFT: edge capturing bit WIDTH-1 loads full word into out, sets vld=1, cnt=0, -> DONE; vld high in the cycle after that edge (latency 0 cycles from last bit edge to registered out).
REQ-015 SHIFT, edge with enb=1,l_s=1: current partial frame discarded, err=1 next cycle, inp captured as bit 0 of new frame, cnt=1, stays SHIFT; out unchanged.
REQ-016 DONE lasts exactly one cycle, vld=1; next edge: enb=1,l_s=1 starts new frame (bit 0 captured, -> SHIFT, back-to-back, no lost bit); otherwise -> IDLE.
REQ-017 vld and err are never high simultaneously; each deasserts after one cycle.
REQ-018 out holds its value between vld pulses, including through stalls and aborts.
REQ-019 Bit ordering: first bit received -> out[0], last -> out[WIDTH-1].
REQ-020 cnt width = $clog2(WIDTH)+1; never exceeds WIDTH-1 in SHIFT.

Reset
REQ-021 rst=1 at an edge: state IDLE, cnt=0, shift register 0, out=0, vld=0, err=0; overrides all other inputs.
REQ-022 rst mid-frame discards partial frame with no vld and no err; first frame after reset requires a fresh l_s.

Structure
REQ-023 Package sipo_pkg holds the state enum typedef (IDLE/SHIFT/DONE) and default WIDTH constant.
REQ-024 One sub-module bit_cnt (load-to-1, increment, clear, terminal flag at WIDTH-1); FSM and shift register stay in sipo_lsb.

Verification
REQ-025 WIDTH=4, frame bits 1,1,0,1 on consecutive enb edges with l_s on first -> out=4'hB, vld one cycle after 4th bit edge, err=0.
REQ-026 Same frame with enb=0 for 3 cycles between bits 2 and 3 -> out=4'hB, vld only after 4th accepted bit.
REQ-027 Two frames back-to-back (4'h5 then 4'hA, l_s on edge after DONE) -> two vld pulses 4 cycles apart, out=5 then A.
REQ-028 l_s reasserted after 2 bits, then 4 bits 0,0,1,1 -> err pulse once, out=4'hC, no vld for aborted frame.
REQ-029 rst asserted after 3 bits of a frame -> out=0, vld=0, err=0; following full frame 4'h7 decoded correctly.
REQ-030 Bits with enb=1,l_s=0 in IDLE (noise) -> no state change, no vld.
